wb_arbiter: RTL and testbench

//  - Shares one Wishbone memory port between the instruction fetch master and the load/store data master.
//  - Sits between core (ifu instr_bus, lsu data_bus) and the memory/interconnect port.
//  - Arbitrates per transfer, not per CYC: ifu holds CYC=1 permanently.
//  - Data has priority; a starvation counter guarantees fetch progress.

---
 rtl/wb_arb_pkg.sv | 29 ++
 rtl/wb_arbiter_if.sv | 37 +++
 rtl/wb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types and defaults for the Wishbone fetch/data arbiter.
//   - arb_state_t : arbiter FSM state (IDLE / HOLD_I / HOLD_D)
//   - arb_sel_t   : which requester is routed to the memory port
//   - cnt_width() : width of the starvation counter for a given limit
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int DEFAULT_XLEN         = 32;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } arb_sel_t;

  // Counter must be able to hold the value STARVE_LIMIT itself.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
//   Classic single-transfer Wishbone bus bundle.
//   Signals: adr, dat_w, dat_r, sel, we, stb, cyc, ack.
//   Modports:
//   - master : drives adr/dat_w/sel/we/stb/cyc, receives dat_r/ack
//   - slave  : receives adr/dat_w/sel/we/stb/cyc, drives dat_r/ack
//
//   Handshake: a requester asks for a transfer while cyc & stb are both high
//   and keeps adr/dat_w/sel/we stable; the transfer completes in the cycle
//   where ack is high together with cyc & stb. dat_r is meaningful only in
//   that ack cycle. Dropping cyc or stb before ack abandons the transfer.
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int XLEN = 32
) ();
  localparam int SELW = XLEN / 8;

  logic [XLEN-1:0] adr;
  logic [XLEN-1:0] dat_w;
  logic [XLEN-1:0] dat_r;
  logic [SELW-1:0] sel;
  logic            we;
  logic            stb;
  logic            cyc;
  logic            ack;

  modport master (
    output adr, dat_w, sel, we, stb, cyc,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Shares one Wishbone memory port between the instruction fetch master
//   and the load/store data master. Arbitration is per transfer (fetch keeps
//   CYC high permanently, so CYC alone cannot be used as an ownership hint).
//   Data has priority; after STARVE_LIMIT data transfers complete while fetch
//   is waiting, fetch is forced to win the next arbitration.
//
// Ports
//   clk          : clock, all state on posedge
//   rst_n        : asynchronous active-low reset
//   instr_bus    : fetch requester (slave side of the arbiter)
//   data_bus     : load/store requester (slave side of the arbiter)
//   mem_bus      : shared downstream port (master side of the arbiter)
//   grant_d      : 1 while the data master is routed to mem_bus
//   o_state      : current FSM state (debug)
//   o_starve_cnt : current starvation counter (debug)
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  wb_arbiter_if.slave                          instr_bus,
  wb_arbiter_if.slave                          data_bus,
  wb_arbiter_if.master                         mem_bus,
  output logic                                 grant_d,
  output arb_state_t                           o_state,
  output logic [cnt_width(STARVE_LIMIT)-1:0]   o_starve_cnt
);

  localparam int            CW        = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_CNT = CW'(STARVE_LIMIT);
  localparam int            SELW      = XLEN / 8;

  arb_state_t    r_state;
  arb_state_t    w_next_state;
  logic [CW-1:0] r_starve_cnt;
  logic [CW-1:0] w_starve_nxt;

  logic          w_req_i;
  logic          w_req_d;
  logic          w_force_i;
  logic          w_sel_valid;
  arb_sel_t      w_sel;
  logic          w_sel_req;
  logic          w_done;

  assign w_req_i   = instr_bus.cyc & instr_bus.stb;
  assign w_req_d   = data_bus.cyc & data_bus.stb;
  assign w_force_i = (r_starve_cnt == LIMIT_CNT);

  // Selection. In IDLE it is decided combinationally so a transfer can start
  // (and even finish) in the same cycle it is requested. In HOLD_x the held
  // master stays routed whatever the other one does. While rst_n is low
  // nothing is routed, so the memory port and both ACKs are quiet
  // immediately rather than at the next edge.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = SEL_I;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_req_d && !(w_force_i && w_req_i)) begin
            w_sel_valid = 1'b1;
            w_sel       = SEL_D;
          end else if (w_req_i) begin
            w_sel_valid = 1'b1;
            w_sel       = SEL_I;
          end
        end
        HOLD_I: begin
          w_sel_valid = 1'b1;
          w_sel       = SEL_I;
        end
        HOLD_D: begin
          w_sel_valid = 1'b1;
          w_sel       = SEL_D;
        end
        default: begin
          w_sel_valid = 1'b0;
          w_sel       = SEL_I;
        end
      endcase
    end
  end

  // A transfer only completes when the routed master is still asking for
  // it; an ACK arriving while the held master has backed off is not counted
  // and not forwarded.
  assign w_sel_req = (w_sel == SEL_D) ? w_req_d : w_req_i;
  assign w_done    = w_sel_valid & w_sel_req & mem_bus.ack;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        // Same-cycle ACK completes the transfer without leaving IDLE.
        if (w_sel_valid && !mem_bus.ack) begin
          w_next_state = (w_sel == SEL_D) ? HOLD_D : HOLD_I;
        end
      end
      HOLD_I, HOLD_D: begin
        // Leave on completion or when the held master abandons the transfer.
        if (!w_sel_req || mem_bus.ack) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Starvation counter: counts data completions that happen while fetch is
  // waiting, saturates at the limit, and clears as soon as fetch is served or
  // stops asking.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_done) begin
      if (w_sel == SEL_I) begin
        w_starve_nxt = '0;
      end else if (w_req_i) begin
        if (r_starve_cnt != LIMIT_CNT) begin
          w_starve_nxt = r_starve_cnt + 1'b1;
        end
      end else begin
        w_starve_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Routing mux toward the memory port; all-zero when nothing is selected.
  always_comb begin
    mem_bus.adr   = '0;
    mem_bus.dat_w = '0;
    mem_bus.sel   = '0;
    mem_bus.we    = 1'b0;
    mem_bus.stb   = 1'b0;
    mem_bus.cyc   = 1'b0;
    if (w_sel_valid) begin
      if (w_sel == SEL_D) begin
        mem_bus.adr   = data_bus.adr;
        mem_bus.dat_w = data_bus.dat_w;
        mem_bus.sel   = data_bus.sel;
        mem_bus.we    = data_bus.we;
        mem_bus.stb   = data_bus.stb;
        mem_bus.cyc   = data_bus.cyc;
      end else begin
        mem_bus.adr   = instr_bus.adr;
        mem_bus.dat_w = instr_bus.dat_w;
        mem_bus.sel   = instr_bus.sel;
        mem_bus.we    = instr_bus.we;
        mem_bus.stb   = instr_bus.stb;
        mem_bus.cyc   = instr_bus.cyc;
      end
    end
  end

  // ACK only to the routed master; the ifu stalls on ACK=0 when not granted.
  assign instr_bus.ack = w_done & (w_sel == SEL_I);
  assign data_bus.ack  = w_done & (w_sel == SEL_D);

  // Read data is broadcast; each master qualifies it with its own ACK.
  assign instr_bus.dat_r = mem_bus.dat_r;
  assign data_bus.dat_r  = mem_bus.dat_r;

  assign grant_d      = w_sel_valid & (w_sel == SEL_D);
  assign o_state      = r_state;
  assign o_starve_cnt = r_starve_cnt;

  // Keeps the select width tied to XLEN for readers of the mux above.
  logic [SELW-1:0] w_unused_sel_check;
  assign w_unused_sel_check = mem_bus.sel;
  logic w_unused;
  assign w_unused = ^w_unused_sel_check;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Table-driven bench for wb_arbiter. Each vector is one clock cycle:
//   inputs are driven at the falling edge, outputs are compared 1 ns later,
//   then the rising edge advances the DUT.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  localparam logic [1:0] R_N = 2'd0;  // nothing routed
  localparam logic [1:0] R_I = 2'd1;  // fetch routed
  localparam logic [1:0] R_D = 2'd2;  // data routed

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(XLEN)) instr_if ();
  wb_arbiter_if #(.XLEN(XLEN)) data_if ();
  wb_arbiter_if #(.XLEN(XLEN)) mem_if ();

  logic       grant_d;
  arb_state_t state;
  logic [2:0] starve_cnt;

  wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_bus    (instr_if),
    .data_bus     (data_if),
    .mem_bus      (mem_if),
    .grant_d      (grant_d),
    .o_state      (state),
    .o_starve_cnt (starve_cnt)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int seq   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        istb;
    logic [31:0] iadr;
    logic        dcyc;
    logic        dstb;
    logic        dwe;
    logic [31:0] dadr;
    logic        mack;
    logic [1:0]  route;
    logic [1:0]  e_state;
    logic [2:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic istb, input logic [31:0] iadr,
                              input logic dcyc, input logic dstb, input logic dwe,
                              input logic [31:0] dadr, input logic mack,
                              input logic [1:0] route, input logic [1:0] st,
                              input logic [2:0] cnt);
    vec_t v;
    v.rst_n = r;     v.istb = istb;   v.iadr = iadr;
    v.dcyc  = dcyc;  v.dstb = dstb;   v.dwe  = dwe;   v.dadr = dadr;
    v.mack  = mack;  v.route = route; v.e_state = st; v.e_cnt = cnt;
    return v;
  endfunction

  // ---------------- driver + per-cycle compare ----------------
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] rd, e_adr, e_dw;
    logic [3:0]  e_sel;
    logic        e_we, e_stb, e_cyc, e_iack, e_dack;
    @(negedge clk);
    rst_n          = v.rst_n;
    instr_if.cyc   = 1'b1;
    instr_if.stb   = v.istb;
    instr_if.adr   = v.iadr;
    instr_if.dat_w = 32'h0;
    instr_if.sel   = 4'hF;
    instr_if.we    = 1'b0;
    data_if.cyc    = v.dcyc;
    data_if.stb    = v.dstb;
    data_if.we     = v.dwe;
    data_if.adr    = v.dadr;
    data_if.dat_w  = v.dadr ^ 32'h5A5A_0000;
    data_if.sel    = 4'h3;
    rd             = 32'hC0DE_0000 | 32'(seq);
    seq++;
    mem_if.dat_r   = rd;
    mem_if.ack     = v.mack;
    #1;
    e_adr = 32'h0; e_dw = 32'h0; e_sel = 4'h0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0;
    case (v.route)
      R_I: begin
        e_adr = v.iadr; e_dw = 32'h0; e_sel = 4'hF; e_we = 1'b0; e_stb = v.istb; e_cyc = 1'b1;
      end
      R_D: begin
        e_adr = v.dadr; e_dw = v.dadr ^ 32'h5A5A_0000; e_sel = 4'h3; e_we = v.dwe;
        e_stb = v.dstb; e_cyc = v.dcyc;
      end
      default: ;
    endcase
    e_iack = (v.route == R_I) & v.mack;
    e_dack = (v.route == R_D) & v.mack;
    check({tag, ".mem_adr"},   mem_if.adr,           e_adr);
    check({tag, ".mem_datw"},  mem_if.dat_w,         e_dw);
    check({tag, ".mem_sel"},   32'(mem_if.sel),      32'(e_sel));
    check({tag, ".mem_we"},    32'(mem_if.we),       32'(e_we));
    check({tag, ".mem_stb"},   32'(mem_if.stb),      32'(e_stb));
    check({tag, ".mem_cyc"},   32'(mem_if.cyc),      32'(e_cyc));
    check({tag, ".i_ack"},     32'(instr_if.ack),    32'(e_iack));
    check({tag, ".d_ack"},     32'(data_if.ack),     32'(e_dack));
    check({tag, ".grant_d"},   32'(grant_d),         32'(v.route == R_D));
    check({tag, ".i_datr"},    instr_if.dat_r,       rd);
    check({tag, ".d_datr"},    data_if.dat_r,        rd);
    check({tag, ".state"},     32'(state),           32'(v.e_state));
    check({tag, ".starve"},    32'(starve_cnt),      32'(v.e_cnt));
  endtask

  vec_t vecs[24];

  initial begin
    rst_n = 1'b0;
    instr_if.cyc = 1'b0; instr_if.stb = 1'b0; instr_if.adr = '0; instr_if.dat_w = '0;
    instr_if.sel = '0;   instr_if.we = 1'b0;
    data_if.cyc = 1'b0;  data_if.stb = 1'b0;  data_if.adr = '0;  data_if.dat_w = '0;
    data_if.sel = '0;    data_if.we = 1'b0;
    mem_if.ack = 1'b0;   mem_if.dat_r = '0;
    repeat (2) @(posedge clk);

    //                 rst istb iadr        dcyc dstb dwe dadr        ack route st      cnt
    // held in reset with both requesting: nothing routed
    vecs[0]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0, R_N, IDLE,   3'd0);
    // fetch only, same-cycle ACK, three transfers in three cycles
    vecs[1]  = mk(1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, R_I, IDLE,   3'd0);
    vecs[2]  = mk(1'b1, 1'b1, 32'h4,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, R_I, IDLE,   3'd0);
    vecs[3]  = mk(1'b1, 1'b1, 32'h8,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, R_I, IDLE,   3'd0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_N, IDLE,   3'd0);
    // stray ACK with nothing selected: ignored
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, R_N, IDLE,   3'd0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_N, IDLE,   3'd0);
    // both request: data write 0x100 first, fetch waits, then fetch next cycle
    vecs[7]  = mk(1'b1, 1'b1, 32'hC,   1'b1, 1'b1, 1'b1, 32'h100, 1'b0, R_D, IDLE,   3'd0);
    vecs[8]  = mk(1'b1, 1'b1, 32'hC,   1'b1, 1'b1, 1'b1, 32'h100, 1'b0, R_D, HOLD_D, 3'd0);
    vecs[9]  = mk(1'b1, 1'b1, 32'hC,   1'b1, 1'b1, 1'b1, 32'h100, 1'b1, R_D, HOLD_D, 3'd0);
    vecs[10] = mk(1'b1, 1'b1, 32'hC,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1, R_I, IDLE,   3'd1);
    vecs[11] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_N, IDLE,   3'd0);
    // fetch held, ACK after 3 waits, data arrives mid-wait and is kept out
    vecs[12] = mk(1'b1, 1'b1, 32'h10,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_I, IDLE,   3'd0);
    vecs[13] = mk(1'b1, 1'b1, 32'h10,  1'b1, 1'b1, 1'b0, 32'h200, 1'b0, R_I, HOLD_I, 3'd0);
    vecs[14] = mk(1'b1, 1'b1, 32'h10,  1'b1, 1'b1, 1'b0, 32'h200, 1'b0, R_I, HOLD_I, 3'd0);
    vecs[15] = mk(1'b1, 1'b1, 32'h10,  1'b1, 1'b1, 1'b0, 32'h200, 1'b1, R_I, HOLD_I, 3'd0);
    vecs[16] = mk(1'b1, 1'b0, 32'h10,  1'b1, 1'b1, 1'b0, 32'h200, 1'b1, R_D, IDLE,   3'd0);
    vecs[17] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_N, IDLE,   3'd0);
    // data abort: drops STB in HOLD_D, counter stays at 1, pending fetch wins
    vecs[18] = mk(1'b1, 1'b1, 32'h14,  1'b1, 1'b1, 1'b1, 32'h300, 1'b1, R_D, IDLE,   3'd0);
    vecs[19] = mk(1'b1, 1'b1, 32'h14,  1'b1, 1'b1, 1'b1, 32'h300, 1'b0, R_D, IDLE,   3'd1);
    vecs[20] = mk(1'b1, 1'b1, 32'h14,  1'b1, 1'b0, 1'b1, 32'h300, 1'b0, R_D, HOLD_D, 3'd1);
    vecs[21] = mk(1'b1, 1'b1, 32'h14,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_I, IDLE,   3'd1);
    vecs[22] = mk(1'b1, 1'b1, 32'h14,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1, R_I, HOLD_I, 3'd1);
    vecs[23] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_N, IDLE,   3'd0);

    for (int i = 0; i < 24; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Starvation: both request every cycle with same-cycle ACK.
    // Expected grant pattern D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(((k % 5) == 4) ? R_I : R_D);
    end
    for (int k = 0; k < 10; k++) begin
      logic [1:0] r;
      r = exp_q.pop_front();
      apply(mk(1'b1, 1'b1, 32'h40 + 32'(4 * k), 1'b1, 1'b1, 1'b0, 32'h400 + 32'(4 * k),
               1'b1, r, IDLE, 3'(k % 5)), $sformatf("starve%0d", k));
    end

    // Reset during HOLD_D with ACK pending, then fetch-only recovery.
    apply(mk(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, R_D, IDLE,   3'd0), "rst_a");
    apply(mk(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, R_D, IDLE,   3'd1), "rst_b");
    apply(mk(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, R_D, HOLD_D, 3'd1), "rst_c");
    apply(mk(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, R_N, IDLE,   3'd0), "rst_d");
    apply(mk(1'b1, 1'b1, 32'h84, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, R_I, IDLE,   3'd0), "rst_e");
    apply(mk(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, R_N, IDLE,   3'd0), "rst_f");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
